// File: rtl/tick_timer_arbiter_if.sv
// rtl/tick_timer_arbiter_if.sv - requester/timer bundle between client FSMs and the shared tick timer
interface tick_timer_arbiter_if #(
   parameter int NUM_REQ     = 4,
   parameter int DELAY_WIDTH = 10
);
   logic [NUM_REQ-1:0]             req;
   logic [NUM_REQ*DELAY_WIDTH-1:0] delay;
   logic [NUM_REQ-1:0]             grant;
   logic [NUM_REQ-1:0]             done;
   logic                           busy;
   logic [DELAY_WIDTH-1:0]         remaining;

   modport master (
      output req, delay,
      input  grant, done, busy, remaining
   );

   modport slave (
      input  req, delay,
      output grant, done, busy, remaining
   );
endinterface

// File: rtl/tick_timer_arbiter.sv
// rtl/tick_timer_arbiter.sv - round-robin sharing of one prescaled tick countdown timer
module tick_timer_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int DELAY_WIDTH    = 10,
   parameter int PRESCALE       = 1000,
   parameter int PRESCALE_WIDTH = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   tick_timer_arbiter_if.slave  bus
);
   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                    state_q;
   logic [NUM_REQ-1:0]        grant_q;
   logic [NUM_REQ-1:0]        done_q;
   logic                      busy_q;
   logic [DELAY_WIDTH-1:0]    remaining_q;
   logic [PRESCALE_WIDTH-1:0] presc_q;
   logic [IDX_W-1:0]          last_q;

   logic                      win_found;
   logic [IDX_W-1:0]          last_d;
   logic [DELAY_WIDTH-1:0]    remaining_d;
   logic                      owner_req;

   function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
      logic [IDX_W:0] s;
      s = {1'b0, base} + (IDX_W+1)'(off);
      if (s >= (IDX_W+1)'(NUM_REQ)) s = s - (IDX_W+1)'(NUM_REQ);
      return s[IDX_W-1:0];
   endfunction

   // Search starts just after the previous winner, so the last owner has lowest priority.
   always_comb begin
      win_found = 1'b0;
      last_d    = last_q;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!win_found && bus.req[wrap_idx(last_q, k)]) begin
            win_found = 1'b1;
            last_d    = wrap_idx(last_q, k);
         end
      end
   end

   always_comb begin
      remaining_d = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (last_d == IDX_W'(i)) remaining_d = bus.delay[i*DELAY_WIDTH +: DELAY_WIDTH];
      end
   end

   assign owner_req = |(bus.req & grant_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         done_q      <= '0;
         busy_q      <= 1'b0;
         remaining_q <= '0;
         presc_q     <= '0;
         last_q      <= IDX_W'(NUM_REQ - 1);
      end else begin
         done_q <= '0;
         case (state_q)
            IDLE: begin
               if (win_found) begin
                  state_q     <= RUN;
                  grant_q     <= NUM_REQ'(1) << last_d;
                  busy_q      <= 1'b1;
                  remaining_q <= remaining_d;
                  presc_q     <= '0;
                  last_q      <= last_d;
               end
            end
            RUN: begin
               if (!owner_req) begin
                  state_q     <= IDLE;
                  grant_q     <= '0;
                  busy_q      <= 1'b0;
                  remaining_q <= '0;
               end else if (remaining_q == '0) begin
                  state_q <= DONE;
                  done_q  <= grant_q;
               end else if (presc_q == PRESCALE_WIDTH'(PRESCALE - 1)) begin
                  presc_q     <= '0;
                  remaining_q <= remaining_q - DELAY_WIDTH'(1);
               end else begin
                  presc_q <= presc_q + PRESCALE_WIDTH'(1);
               end
            end
            DONE: begin
               state_q     <= IDLE;
               grant_q     <= '0;
               busy_q      <= 1'b0;
               remaining_q <= '0;
            end
            default: begin
               state_q     <= IDLE;
               grant_q     <= '0;
               busy_q      <= 1'b0;
               remaining_q <= '0;
            end
         endcase
      end
   end

   assign bus.grant     = grant_q;
   assign bus.done      = done_q;
   assign bus.busy      = busy_q;
   assign bus.remaining = remaining_q;
endmodule

// File: tb/tb_tick_timer_arbiter.sv
// tb/tb_tick_timer_arbiter.sv - randomized bench against an event-timing reference model
module tb_tick_timer_arbiter;
   localparam int N  = 4;
   localparam int DW = 10;
   localparam int P  = 4;
   localparam int PW = 10;

   logic clk;
   logic rst;

   tick_timer_arbiter_if #(.NUM_REQ(N), .DELAY_WIDTH(DW)) bus ();

   tick_timer_arbiter #(
      .NUM_REQ(N), .DELAY_WIDTH(DW), .PRESCALE(P), .PRESCALE_WIDTH(PW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Model: owner (-1 idle), edges since grant k, granted delay D, pointer last.
   int m_owner;
   int m_k;
   int m_d;
   int m_last;

   logic [N-1:0]    cur_req;
   logic [N*DW-1:0] cur_dly;

   task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input logic [N-1:0] r, input logic [N*DW-1:0] d, input logic rs);
      if (rs) begin
         m_owner = -1;
         m_last  = N - 1;
      end else if (m_owner < 0) begin
         for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (r[c]) begin
               m_owner = c;
               m_last  = c;
               m_k     = 0;
               m_d     = int'(d[c*DW +: DW]);
               break;
            end
         end
      end else if (m_k == m_d * P + 1) begin
         m_owner = -1;
      end else if (!r[m_owner]) begin
         m_owner = -1;
      end else begin
         m_k++;
      end
   endtask

   task automatic step(input logic [N-1:0] r, input logic [N*DW-1:0] d, input logic rs);
      int exp_g, exp_dn, exp_b, exp_rem;
      @(negedge clk);
      exp_g = 0; exp_dn = 0; exp_b = 0; exp_rem = 0;
      if (m_owner >= 0) begin
         exp_g   = 1 << m_owner;
         exp_b   = 1;
         exp_rem = (m_k <= m_d * P) ? (m_d - m_k / P) : 0;
         exp_dn  = (m_k == m_d * P + 1) ? exp_g : 0;
      end
      expect_eq("grant",     32'(bus.grant),     32'(exp_g));
      expect_eq("done",      32'(bus.done),      32'(exp_dn));
      expect_eq("busy",      32'(bus.busy),      32'(exp_b));
      expect_eq("remaining", 32'(bus.remaining), 32'(exp_rem));
      bus.req   = r;
      bus.delay = d;
      rst       = rs;
      model_edge(r, d, rs);
   endtask

   initial begin
      logic [N*DW-1:0] dl;
      rst       = 1'b1;
      bus.req   = '0;
      bus.delay = '0;
      repeat (2) @(posedge clk);
      m_owner = -1; m_last = N - 1; m_k = 0; m_d = 0;

      // single requester, delay 3
      dl = '0; dl[2*DW +: DW] = 10'd3;
      repeat (20) step(4'b0100, dl, 1'b0);
      step('0, '0, 1'b0);

      // all requesting with zero delay: rotation
      repeat (14) step(4'b1111, '0, 1'b0);
      repeat (2) step('0, '0, 1'b0);

      // abort, then fairness after abort
      dl = '0; dl[1*DW +: DW] = 10'd5;
      repeat (8) step(4'b0010, dl, 1'b0);
      step('0, dl, 1'b0);
      repeat (6) step(4'b1010, '0, 1'b0);
      repeat (2) step('0, '0, 1'b0);

      // reset in RUN with remaining 2
      dl = '0; dl[0 +: DW] = 10'd3;
      repeat (6) step(4'b0001, dl, 1'b0);
      step(4'b0001, dl, 1'b1);
      repeat (4) step(4'b1010, '0, 1'b0);
      repeat (2) step('0, '0, 1'b0);

      // maximum delay with delay inputs churning during RUN
      dl = '0; dl[0 +: DW] = '1;
      step(4'b0001, dl, 1'b0);
      for (int i = 0; i < 1023 * P + 4; i++)
         step(4'b0001, (N*DW)'({$urandom(), $urandom()}), 1'b0);
      repeat (2) step('0, '0, 1'b0);

      // random traffic with aborts, resets and delay changes
      cur_req = '0;
      cur_dly = '0;
      for (int i = 0; i < 3000; i++) begin
         for (int j = 0; j < N; j++) begin
            if (!cur_req[j]) begin
               if ($urandom_range(0, 5) == 0) cur_req[j] = 1'b1;
            end else if ($urandom_range(0, 39) == 0) begin
               cur_req[j] = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) cur_dly[j*DW +: DW] = DW'($urandom_range(0, 6));
         end
         step(cur_req, cur_dly, ($urandom_range(0, 199) == 0));
      end
      step('0, '0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
